// File: rtl/pingpang_unpack.sv
// Ping-pong frame receiver: packs a single word stream into two frame banks
// and drains ping frames to channel A and pong frames to channel B, strictly alternating.
module pingpang_unpack #(
   parameter int DW = 16,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] data_in,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] data_out_a,
   output logic          out_valid_a,
   input  logic          out_ready_a,
   output logic [DW-1:0] data_out_b,
   output logic          out_valid_b,
   input  logic          out_ready_b,
   output logic [7:0]    frame_cnt_a,
   output logic [7:0]    frame_cnt_b
);

   typedef enum logic {RD_PING = 1'b0, RD_PONG = 1'b1} rd_state_t;

   logic [DW-1:0] mem0_r [DEPTH];
   logic [DW-1:0] mem1_r [DEPTH];
   logic [1:0]    full_r;
   logic          wr_bank_r;
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   rd_state_t     state_r;
   logic [7:0]    frame_cnt_a_r;
   logic [7:0]    frame_cnt_b_r;

   logic          wr_acc_s;
   logic          wr_last_s;
   logic          rd_acc_s;
   logic          rd_last_s;
   logic [DW-1:0] rd_word_s;
   logic [1:0]    full_set_s;
   logic [1:0]    full_clr_s;
   logic [1:0]    full_nxt_s;

   // Handshakes, output views of the registered state, and next-state of the bank flags.
   always_comb begin
      in_ready    = !rst && !full_r[wr_bank_r];
      wr_acc_s    = in_valid && in_ready;
      wr_last_s   = (wr_ptr_r == AW'(DEPTH - 1));
      out_valid_a = full_r[0] && (state_r == RD_PING);
      out_valid_b = full_r[1] && (state_r == RD_PONG);
      rd_acc_s    = (out_valid_a && out_ready_a) || (out_valid_b && out_ready_b);
      rd_last_s   = (rd_ptr_r == AW'(DEPTH - 1));
      rd_word_s   = (state_r == RD_PONG) ? mem1_r[rd_ptr_r] : mem0_r[rd_ptr_r];
      data_out_a  = out_valid_a ? rd_word_s : {DW{1'b0}};
      data_out_b  = out_valid_b ? rd_word_s : {DW{1'b0}};
      // A bank cannot be set and cleared at once: set needs it empty, clear needs it full.
      full_set_s  = (wr_acc_s && wr_last_s) ? (wr_bank_r ? 2'b10 : 2'b01) : 2'b00;
      full_clr_s  = (rd_acc_s && rd_last_s) ? ((state_r == RD_PONG) ? 2'b10 : 2'b01) : 2'b00;
      full_nxt_s  = (full_r | full_set_s) & ~full_clr_s;
      frame_cnt_a = frame_cnt_a_r;
      frame_cnt_b = frame_cnt_b_r;
   end

   // Frame storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         if (wr_bank_r) begin
            mem1_r[wr_ptr_r] <= data_in;
         end else begin
            mem0_r[wr_ptr_r] <= data_in;
         end
      end
   end

   // Write pointer/bank, read FSM, bank flags and frame counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_r        <= 2'b00;
         wr_bank_r     <= 1'b0;
         wr_ptr_r      <= {AW{1'b0}};
         rd_ptr_r      <= {AW{1'b0}};
         state_r       <= RD_PING;
         frame_cnt_a_r <= 8'd0;
         frame_cnt_b_r <= 8'd0;
      end else begin
         full_r <= full_nxt_s;
         if (wr_acc_s) begin
            if (wr_last_s) begin
               wr_ptr_r  <= {AW{1'b0}};
               wr_bank_r <= ~wr_bank_r;
            end else begin
               wr_ptr_r  <= wr_ptr_r + AW'(1);
            end
         end
         if (rd_acc_s) begin
            if (rd_last_s) begin
               rd_ptr_r <= {AW{1'b0}};
               if (state_r == RD_PING) begin
                  frame_cnt_a_r <= frame_cnt_a_r + 8'd1;
                  state_r       <= RD_PONG;
               end else begin
                  frame_cnt_b_r <= frame_cnt_b_r + 8'd1;
                  state_r       <= RD_PING;
               end
            end else begin
               rd_ptr_r <= rd_ptr_r + AW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_pingpang_unpack.sv
// Randomised/directed bench for pingpang_unpack with a word-queue scoreboard and
// a frame-level reference model (fill count vs. drain count).
module tb_pingpang_unpack;

   localparam int DW = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] data_in = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] data_out_a, data_out_b;
   logic          out_valid_a, out_valid_b;
   logic          out_ready_a = 1'b0;
   logic          out_ready_b = 1'b0;
   logic [7:0]    frame_cnt_a, frame_cnt_b;

   int n_checks = 0;
   int n_pass = 0;

   logic [DW-1:0] exp_q[$];
   int words_in = 0;
   int words_out = 0;

   pingpang_unpack #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
      .data_out_a(data_out_a), .out_valid_a(out_valid_a), .out_ready_a(out_ready_a),
      .data_out_b(data_out_b), .out_valid_b(out_valid_b), .out_ready_b(out_ready_b),
      .frame_cnt_a(frame_cnt_a), .frame_cnt_b(frame_cnt_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
   endtask

   // Scoreboard: compare outputs against the frame model, then apply this cycle's handshakes.
   always @(negedge clk) begin
      int filled, drained;
      logic exp_va, exp_vb;
      logic [DW-1:0] exp_d;
      if (rst) begin
         chk("in_ready_in_reset", int'(in_ready), 0);
         exp_q.delete();
         words_in = 0;
         words_out = 0;
      end else begin
         filled  = words_in / DEPTH;
         drained = words_out / DEPTH;
         exp_va  = (filled > drained) && (drained % 2 == 0);
         exp_vb  = (filled > drained) && (drained % 2 == 1);
         exp_d   = (exp_q.size() > 0) ? exp_q[0] : '0;
         chk("in_ready", int'(in_ready), int'((filled - drained) < 2));
         chk("out_valid_a", int'(out_valid_a), int'(exp_va));
         chk("out_valid_b", int'(out_valid_b), int'(exp_vb));
         chk("data_out_a", int'(data_out_a), exp_va ? int'(exp_d) : 0);
         chk("data_out_b", int'(data_out_b), exp_vb ? int'(exp_d) : 0);
         chk("frame_cnt_a", int'(frame_cnt_a), ((drained + 1) / 2) % 256);
         chk("frame_cnt_b", int'(frame_cnt_b), (drained / 2) % 256);
         if (in_valid && in_ready) begin
            exp_q.push_back(data_in);
            words_in++;
         end
         if ((out_valid_a && out_ready_a) || (out_valid_b && out_ready_b)) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            words_out++;
         end
      end
   end

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      cycles(1);
      rst = 1'b0;
   endtask

   task automatic push(input logic [DW-1:0] d);
      data_in = d;
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
      end
      chk("push_timeout", 1, 0);
      in_valid = 1'b0;
   endtask

   initial begin
      int stall_ok;
      cycles(3);
      rst = 1'b0;

      // Single frame to channel A
      out_ready_a = 1'b1;
      out_ready_b = 1'b1;
      for (int i = 1; i <= 4; i++) push(DW'(i));
      cycles(8);

      // Continuous alternation, including simultaneous clear/set of the banks
      pulse_reset();
      for (int i = 16'h10; i <= 16'h1F; i++) push(DW'(i));
      cycles(12);

      // Backpressure: A stalled, two banks fill, ninth word held
      pulse_reset();
      out_ready_a = 1'b0;
      for (int i = 0; i < 8; i++) push(DW'(16'h100 + i));
      data_in = 16'h0109;
      in_valid = 1'b1;
      cycles(5);
      stall_ok = int'(!in_ready);
      chk("ninth_word_held", stall_ok, 1);
      out_ready_a = 1'b1;
      push(16'h0109);
      cycles(12);

      // Reset in the middle of a frame
      push(16'h0055);
      push(16'h0066);
      pulse_reset();
      for (int i = 16'hAA; i <= 16'hAD; i++) push(DW'(i));
      cycles(8);
      chk("reset_frame_cnt_a", int'(frame_cnt_a), 1);
      chk("reset_frame_cnt_b", int'(frame_cnt_b), 0);

      // Counter wrap: 512 frames of random data
      pulse_reset();
      for (int i = 0; i < 512 * DEPTH; i++) push(DW'($urandom));
      cycles(8);
      chk("wrap_frame_cnt_a", int'(frame_cnt_a), 0);
      chk("wrap_frame_cnt_b", int'(frame_cnt_b), 0);

      // Random valid/ready traffic
      for (int i = 0; i < 600; i++) begin
         in_valid = 1'($urandom % 2);
         data_in = DW'($urandom);
         out_ready_a = 1'($urandom % 4 != 0);
         out_ready_b = 1'($urandom % 4 != 0);
         cycles(1);
      end
      in_valid = 1'b0;
      out_ready_a = 1'b1;
      out_ready_b = 1'b1;
      cycles(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
